// File: rtl/memb_pkg.sv
// Shared types and helpers for the double-buffered B-operand memory.
package memb_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2,
      READING = 2'd3
   } bank_state_t;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } rd_state_t;

   // Stream cycles per matrix: the skewed diagonal needs 2*DIM-1 cycles to drain.
   function automatic int unsigned stream_len(input int unsigned dim, input bit skew_en);
      return skew_en ? (2 * dim - 1) : dim;
   endfunction

endpackage

// File: rtl/memb_bank.sv
// One DIM x DIM B bank: whole-row write, independent row select per column on read.
module memb_bank
   import memb_pkg::*;
#(
   parameter int unsigned BITS_AB = 8,
   parameter int unsigned DIM     = 8,
   parameter int unsigned ROWBITS = $clog2(DIM)
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [ROWBITS-1:0]       waddr,
   input  logic [DIM*BITS_AB-1:0]   wdata,
   input  logic [DIM*ROWBITS-1:0]   rrow,
   input  logic [DIM-1:0]           rzero,
   output logic [DIM*BITS_AB-1:0]   rdata_c
);

   // Contents are don't-care after reset, so the array carries no reset.
   logic [DIM*BITS_AB-1:0] mem [DIM];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Column c reads element c of its own selected row, or zero padding.
   always_comb begin
      rdata_c = '0;
      for (int c = 0; c < DIM; c++) begin
         if (!rzero[c]) begin
            rdata_c[c*BITS_AB +: BITS_AB] = mem[rrow[c*ROWBITS +: ROWBITS]][c*BITS_AB +: BITS_AB];
         end
      end
   end

endmodule

// File: rtl/memb_pingpong_skew.sv
// Ping-pong B memory: fills one bank while the other streams, diagonally skewed,
// into the top edge of the systolic array.
module memb_pingpong_skew
   import memb_pkg::*;
#(
   parameter int unsigned BITS_AB = 8,
   parameter int unsigned DIM     = 8,
   parameter int unsigned SKEW_EN = 1,
   parameter int unsigned ROWBITS = $clog2(DIM)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [DIM*BITS_AB-1:0] Bin,
   input  logic                   rd_en,
   output logic [DIM*BITS_AB-1:0] Bout,
   output logic                   bout_valid,
   output logic                   stream_last,
   output logic [1:0]             banks_full
);

   localparam int unsigned SLEN = stream_len(DIM, SKEW_EN != 0);
   localparam int unsigned CNTW = $clog2(2 * DIM);
   localparam int unsigned ROWW = DIM * BITS_AB;

   bank_state_t         bank_st   [2];
   bank_state_t         bank_st_n [2];
   rd_state_t           rd_st;
   logic                wr_bank;
   logic                rd_bank;
   logic [ROWBITS-1:0]  wr_row;
   logic [CNTW-1:0]     t;

   logic                accept;
   logic                wr_done;
   logic                adv;
   logic                fin;
   logic                start;
   logic                chain;
   logic                rd_other;
   logic                wr_bank_n;
   logic                wr_ready_d;
   logic [1:0]          banks_full_d;

   logic [DIM*ROWBITS-1:0] rd_row;
   logic [DIM-1:0]         rd_zero;
   logic [ROWW-1:0]        bank_rdata [2];
   logic [ROWW-1:0]        rd_data_c;

   // Handshake and stream events for this cycle.
   always_comb begin
      rd_other = ~rd_bank;
      accept   = wr_valid && wr_ready;
      wr_done  = accept && (wr_row == ROWBITS'(DIM - 1));
      adv      = (rd_st == STREAM) && rd_en;
      fin      = adv && (t == CNTW'(SLEN - 1));
      chain    = fin && (bank_st[rd_other] == FULL);
      start    = (rd_st == IDLE) && rd_en && (bank_st[rd_bank] == FULL);
   end

   // Bank lifecycle; the write bank only ever holds EMPTY/FILLING and the read
   // bank FULL/READING, so the two sides never update the same entry.
   always_comb begin
      bank_st_n = bank_st;
      if (accept) begin
         bank_st_n[wr_bank] = wr_done ? FULL : FILLING;
      end
      if (start) begin
         bank_st_n[rd_bank] = READING;
      end
      if (fin) begin
         bank_st_n[rd_bank] = EMPTY;
      end
      if (chain) begin
         bank_st_n[rd_other] = READING;
      end
   end

   // A bank freed this cycle is withheld from the writer for one more cycle.
   always_comb begin
      wr_bank_n  = wr_bank ^ wr_done;
      wr_ready_d = ((bank_st_n[wr_bank_n] == EMPTY) || (bank_st_n[wr_bank_n] == FILLING))
                   && !(fin && (rd_bank == wr_bank_n));
      banks_full_d[0] = (bank_st_n[0] == FULL);
      banks_full_d[1] = (bank_st_n[1] == FULL);
   end

   // Column c shows row t-c when skewed; out-of-range rows pad with zero.
   always_comb begin
      rd_row  = '0;
      rd_zero = '0;
      for (int c = 0; c < DIM; c++) begin
         if (SKEW_EN != 0) begin
            if ((CNTW'(c) > t) || ((t - CNTW'(c)) >= CNTW'(DIM))) begin
               rd_zero[c] = 1'b1;
            end else begin
               rd_row[c*ROWBITS +: ROWBITS] = ROWBITS'(t - CNTW'(c));
            end
         end else begin
            rd_row[c*ROWBITS +: ROWBITS] = ROWBITS'(t);
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      memb_bank #(
         .BITS_AB (BITS_AB),
         .DIM     (DIM),
         .ROWBITS (ROWBITS)
      ) u_bank (
         .clk     (clk),
         .we      (accept && (wr_bank == 1'(b))),
         .waddr   (wr_row),
         .wdata   (Bin),
         .rrow    (rd_row),
         .rzero   (rd_zero),
         .rdata_c (bank_rdata[b])
      );
   end

   always_comb begin
      rd_data_c = bank_rdata[rd_bank];
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_st[0]  <= EMPTY;
         bank_st[1]  <= EMPTY;
         rd_st       <= IDLE;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         wr_row      <= '0;
         t           <= '0;
         Bout        <= '0;
         bout_valid  <= 1'b0;
         stream_last <= 1'b0;
         wr_ready    <= 1'b1;
         banks_full  <= 2'b00;
      end else begin
         bank_st[0] <= bank_st_n[0];
         bank_st[1] <= bank_st_n[1];
         wr_bank    <= wr_bank_n;
         wr_ready   <= wr_ready_d;
         banks_full <= banks_full_d;

         if (accept) begin
            wr_row <= wr_done ? '0 : wr_row + 1'b1;
         end

         case (rd_st)
            IDLE: begin
               Bout        <= '0;
               bout_valid  <= 1'b0;
               stream_last <= 1'b0;
               if (start) begin
                  rd_st <= STREAM;
                  t     <= '0;
               end
            end
            STREAM: begin
               if (rd_en) begin
                  Bout        <= rd_data_c;
                  bout_valid  <= 1'b1;
                  stream_last <= fin;
                  if (fin) begin
                     t       <= '0;
                     rd_bank <= rd_other;
                     if (!chain) begin
                        rd_st <= IDLE;
                     end
                  end else begin
                     t <= t + 1'b1;
                  end
               end else begin
                  bout_valid  <= 1'b0;
                  stream_last <= 1'b0;
               end
            end
            default: begin
               rd_st <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/memb_pingpong_skew.md
Name: memb_pingpong_skew

Overview:
- Double-buffered B-operand memory for the systolic array; successor to the single-bank B memory.
- Accepts B one row per cycle through a valid/ready write port into one of two banks.
- Streams the other bank into the array top edge with per-column diagonal skew (column c delayed c cycles) and zero padding.
- Lets matrix N+1 load while matrix N computes, removing the fill bubble between tiles.

Parameters:
- BITS_AB, 8, signed element width.
- DIM, 8, array dimension: rows per matrix and columns per row.
- SKEW_EN, 1, 1 = diagonal skew on output; 0 = all columns aligned (row t on every column at stream cycle t).
- ROWBITS, $clog2(DIM), row index width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  Bin holds a valid row
- wr_ready  out  1  a bank is accepting rows
- Bin  in  signed [BITS_AB-1:0] x DIM  one B row; element c is column c
- rd_en  in  1  permission to start or continue streaming
- Bout  out  signed [BITS_AB-1:0] x DIM  registered column outputs to array top
- bout_valid  out  1  Bout carries stream data this cycle
- stream_last  out  1  final stream cycle of current matrix
- banks_full  out  2  per-bank full flags, for status

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state:
  - Both banks EMPTY; wr_bank = 0, rd_bank = 0, counters 0.
  - Outputs: Bout all 0, bout_valid 0, stream_last 0, wr_ready 1, banks_full 2'b00.
  - Bank storage contents are don't-care.
- Bank states: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
- Write side:
  - wr_ready = (bank[wr_bank] is EMPTY or FILLING). It is registered-state based and never combinational from rd_en.
  - On wr_valid && wr_ready: store Bin at row wr_row of bank[wr_bank]; wr_row++.
  - When the row stored is DIM-1: bank goes FULL, wr_row returns to 0, wr_bank toggles.
  - wr_valid while not ready: no state change, data dropped.
- Read FSM (states IDLE, STREAM):
  - IDLE -> STREAM when rd_en && bank[rd_bank] FULL. That bank becomes READING; stream counter t = 0.
  - STREAM length: L = 2*DIM-1 cycles if SKEW_EN, else DIM cycles.
  - t advances only when rd_en = 1. rd_en = 0 in STREAM holds t and Bout (stall) and drives bout_valid 0.
  - Output latency is one cycle: on each advancing cycle with count t, the next-cycle Bout[c] = B[t-c][c] if 0 <= t-c < DIM, else 0. With SKEW_EN = 0, Bout[c] = B[t][c].
  - bout_valid = 1 and stream_last = (t == L-1) in the cycle the data appears.
- End of stream:
  - On the advancing cycle with t == L-1: bank -> EMPTY, rd_bank toggles.
  - If rd_en and the other bank is FULL, the next stream starts the next cycle with no gap (back-to-back). Otherwise return to IDLE.
- Idle output: while IDLE, Bout is forced to 0 and bout_valid to 0.
- Simultaneous events:
  - Freeing a bank and write-checking it in the same cycle: the freed bank is visible to wr_ready only on the following cycle.
  - Write into one bank while the other streams is always legal.
  - A bank cannot be read before FULL, even if rows are partially written.
- Reset mid-stream or mid-fill: everything returns to the reset state immediately. A partial matrix is discarded.
- Width: pure storage and muxing, no arithmetic on data. Signed values pass through unmodified.

Decomposition:
- Package memb_pkg:
  - bank_state_t enum: EMPTY, FILLING, FULL, READING.
  - rd_state_t enum: IDLE, STREAM.
  - Helper function stream_len(DIM, SKEW_EN).
- Sub-module memb_bank: one DIM x DIM register bank with a row write port and per-column row-select read (row index per column, plus a zero flag). Instantiated twice.
- Top level holds both FSMs, the counters and the output register.

Test Plan:
- Basic skew (DIM=4, SKEW_EN=1):
  - Stimulus: write rows B[r][c] = 10r+c, then hold rd_en = 1.
  - Response: 7 valid cycles. Cycle 0 gives Bout = {0,0,0,0}, cycle 1 gives Bout = {10,1,0,0} (element 0 first). Stream ends {0,0,0,33}, with stream_last on the 7th valid cycle.
- Ping-pong overlap:
  - Stimulus: write matrix A, start the stream, write matrix B during the stream.
  - Response: wr_ready stays 1. Matrix B's stream follows A's last cycle with zero idle cycles.
- Backpressure:
  - Stimulus: both banks FULL.
  - Response: wr_ready = 0, and a 9th row is dropped. After the first stream_last, wr_ready rises exactly one cycle later.
- Stall: deassert rd_en for 3 cycles at t = 2 -> Bout holds, bout_valid 0. Resume continues at t = 3 with no lost or duplicated rows.
- No-skew mode: SKEW_EN = 0, same data -> 4 valid cycles, Bout = {30,31,32,33} on the last.
- Reset mid-operation: assert rst_n low mid-stream with the other bank half-filled -> all outputs at reset values asynchronously. A fresh full matrix then streams correctly.
